// File: rtl/to_upper_ascii.sv
// Byte-wide ASCII lower-to-upper case converter. Only bit 5 is ever touched,
// and only for 'a'..'z'; the result is optionally registered with a sync clear.
module to_upper_ascii #(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic a4,
  input  logic a5,
  input  logic a6,
  input  logic a7,
  output logic a0_out,
  output logic a1_out,
  output logic a2_out,
  output logic a3_out,
  output logic a4_out,
  output logic a5_out,
  output logic a6_out,
  output logic a7_out
);

  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] q;
  logic       is_lower;

  assign x = {a7, a6, a5, a4, a3, a2, a1, a0};

  // Unsigned range compare; extended codes fall outside and pass through.
  assign is_lower = (x >= 8'h61) && (x <= 8'h7A);

  assign y = {x[7:6], x[5] & ~is_lower, x[4:0]};

  generate
    if (REGISTER_OUTPUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) q <= 8'h00;
        else     q <= y;
      end
    end else begin : g_comb
      assign q = y;
    end
  endgenerate

  assign {a7_out, a6_out, a5_out, a4_out, a3_out, a2_out, a1_out, a0_out} = q;

endmodule

// File: tb/tb_to_upper_ascii.sv
// Self-checking bench for to_upper_ascii: registered and combinational builds
// driven from the same byte, checked against a plain case-rule reference.
module tb_to_upper_ascii;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] q_reg;
  logic [7:0] q_comb;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  to_upper_ascii #(.REGISTER_OUTPUT(1'b1)) dut_reg (
    .clk(clk), .rst(rst),
    .a0(din[0]), .a1(din[1]), .a2(din[2]), .a3(din[3]),
    .a4(din[4]), .a5(din[5]), .a6(din[6]), .a7(din[7]),
    .a0_out(q_reg[0]), .a1_out(q_reg[1]), .a2_out(q_reg[2]), .a3_out(q_reg[3]),
    .a4_out(q_reg[4]), .a5_out(q_reg[5]), .a6_out(q_reg[6]), .a7_out(q_reg[7])
  );

  to_upper_ascii #(.REGISTER_OUTPUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst),
    .a0(din[0]), .a1(din[1]), .a2(din[2]), .a3(din[3]),
    .a4(din[4]), .a5(din[5]), .a6(din[6]), .a7(din[7]),
    .a0_out(q_comb[0]), .a1_out(q_comb[1]), .a2_out(q_comb[2]), .a3_out(q_comb[3]),
    .a4_out(q_comb[4]), .a5_out(q_comb[5]), .a6_out(q_comb[6]), .a7_out(q_comb[7])
  );

  // Reference: letters 'a'..'z' map to their uppercase counterpart, all else as-is.
  function automatic logic [7:0] ref_upper(input int c);
    if (c >= 97 && c <= 122) return 8'(c - 32);
    return 8'(c);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one byte for one edge; check both builds, then check the register
  // holds while the input moves between edges.
  task automatic step(input string tag, input logic [7:0] v, input logic r);
    logic [7:0] exp_reg;
    logic [7:0] nv;
    din = v;
    rst = r;
    #1;
    chk({tag, "_comb"}, q_comb, ref_upper(int'(v)));
    @(posedge clk);
    #1;
    exp_reg = r ? 8'h00 : ref_upper(int'(v));
    chk({tag, "_reg"}, q_reg, exp_reg);
    nv = ~v;
    din = nv;
    #2;
    chk({tag, "_hold"}, q_reg, exp_reg);
    chk({tag, "_comb2"}, q_comb, ref_upper(int'(nv)));
  endtask

  logic [7:0] fixed [0:19];

  initial begin
    rst = 1'b1;
    din = 8'h61;
    @(posedge clk); #1;
    chk("reset0", q_reg, 8'h00);
    @(posedge clk); #1;
    chk("reset1", q_reg, 8'h00);
    chk("reset_comb", q_comb, 8'h41);
    step("release", 8'h61, 1'b0);

    step("lc_a", 8'h61, 1'b0);
    step("lc_m", 8'h6D, 1'b0);
    step("lc_z", 8'h7A, 1'b0);
    chk("lc_z_const", q_reg, 8'h5A);

    fixed = '{8'h28, 8'h48, 8'h7C, 8'h14, 8'h41, 8'h47, 8'h30, 8'h3A, 8'h7F,
              8'h60, 8'h7B, 8'h40, 8'h5B,
              8'hB7, 8'h83, 8'hEB, 8'h92, 8'hCF, 8'h94, 8'hE1};
    foreach (fixed[i]) begin
      step("passthru", fixed[i], 1'b0);
      chk("passthru_const", q_reg, fixed[i]);
    end

    // Exhaustive sweep with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 256; i++)
      step("sweep", 8'(i), i == 8'h80);

    // Random bytes with sparse resets.
    for (int i = 0; i < 300; i++)
      step("rand", 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
